// File: rtl/kd_sort_sequencer_if.sv
// Bus bundle between the kd-tree sort sequencer, the point loader, the search
// logic and the cluster compare-exchange element.
interface kd_sort_sequencer_if #(
    parameter int DIM        = 3,
    parameter int DATA_RANGE = 255,
    parameter int LEVELS     = 3,
    parameter int MAX_SWEEPS = 16
);
    localparam int DW = $clog2(DATA_RANGE);
    localparam int CW = DIM * DW;
    localparam int N  = 2**LEVELS - 1;
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(MAX_SWEEPS + 1);
    localparam int XW = (DIM > 1) ? $clog2(DIM) : 1;

    logic          start;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [SW-1:0] sweep_count;
    logic          ce_en;
    logic          ce_sorting;
    logic          ce_point_prop;
    logic          ce_left_en;
    logic          ce_right_en;
    logic [CW-1:0] ce_left;
    logic [CW-1:0] ce_parent;
    logic [CW-1:0] ce_right;
    logic [XW-1:0] ce_axis;
    logic          ce_stable;
    logic [CW-1:0] ce_new_left;
    logic [CW-1:0] ce_new_parent;
    logic [CW-1:0] ce_new_right;

    modport slave (
        input  start, wr_en, wr_addr, wr_data, rd_addr,
        input  ce_stable, ce_new_left, ce_new_parent, ce_new_right,
        output rd_data, busy, done, timeout, sweep_count,
        output ce_en, ce_sorting, ce_point_prop, ce_left_en, ce_right_en,
        output ce_left, ce_parent, ce_right, ce_axis
    );

    modport master (
        output start, wr_en, wr_addr, wr_data, rd_addr,
        output ce_stable, ce_new_left, ce_new_parent, ce_new_right,
        input  rd_data, busy, done, timeout, sweep_count,
        input  ce_en, ce_sorting, ce_point_prop, ce_left_en, ce_right_en,
        input  ce_left, ce_parent, ce_right, ce_axis
    );
endinterface

// File: rtl/kd_sort_sequencer.sv
// Heap-ordered cluster-center register file that repeatedly sweeps an external
// compare-exchange element over every internal node until the tree is stable.
module kd_sort_sequencer #(
    parameter int DIM        = 3,
    parameter int DATA_RANGE = 255,
    parameter int LEVELS     = 3,
    parameter int MAX_SWEEPS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    kd_sort_sequencer_if.slave   bus
);
    localparam int DW = $clog2(DATA_RANGE);
    localparam int CW = DIM * DW;
    localparam int N  = 2**LEVELS - 1;
    localparam int K  = 2**(LEVELS-1) - 1;
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(MAX_SWEEPS + 1);
    localparam int XW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EVAL,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_mem [N];
    logic [AW-1:0] r_idx;
    logic          r_dirty;
    logic [SW-1:0] r_sweep;
    logic          r_timeout;
    logic [CW-1:0] r_op_left_p0;
    logic [CW-1:0] r_op_parent_p0;
    logic [CW-1:0] r_op_right_p0;
    logic [XW-1:0] r_op_axis_p0;
    logic [AW-1:0] w_left;
    logic [AW-1:0] w_right;
    logic          w_last;
    logic          w_eval;
    logic          w_done;
    logic          w_limit;

    // Split axis = tree level of node idx, cycling through the coordinates.
    function automatic logic [XW-1:0] axis_of(input logic [AW-1:0] idx);
        int v;
        int lvl;
        v   = int'(idx) + 1;
        lvl = 0;
        for (int b = 1; b <= AW; b++) begin
            if (v >= (1 << b)) lvl = b;
        end
        return XW'(lvl % DIM);
    endfunction

    assign w_left  = {r_idx[AW-2:0], 1'b1};
    assign w_right = {r_idx[AW-2:0], 1'b0} + AW'(2);
    assign w_last  = (r_idx == AW'(K - 1));
    assign w_limit = (r_sweep == SW'(MAX_SWEEPS));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_eval = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_ISSUE;
            S_ISSUE: w_next = S_EVAL;
            S_EVAL: begin
                w_eval = 1'b1;
                w_next = w_last ? S_CHECK : S_ISSUE;
            end
            S_CHECK: begin
                if (!r_dirty || w_limit) w_next = S_DONE;
                else                     w_next = S_ISSUE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ISSUE captures operands; EVAL writes the CE results back in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx          <= '0;
            r_dirty        <= 1'b0;
            r_sweep        <= '0;
            r_timeout      <= 1'b0;
            r_op_left_p0   <= '0;
            r_op_parent_p0 <= '0;
            r_op_right_p0  <= '0;
            r_op_axis_p0   <= '0;
            for (int n = 0; n < N; n++) r_mem[n] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_en && (bus.wr_addr < AW'(N))) r_mem[bus.wr_addr] <= bus.wr_data;
                    if (bus.start) begin
                        r_idx     <= '0;
                        r_dirty   <= 1'b0;
                        r_sweep   <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_op_left_p0   <= r_mem[w_left];
                    r_op_parent_p0 <= r_mem[r_idx];
                    r_op_right_p0  <= r_mem[w_right];
                    r_op_axis_p0   <= axis_of(r_idx);
                end
                S_EVAL: begin
                    r_mem[w_left]  <= bus.ce_new_left;
                    r_mem[r_idx]   <= bus.ce_new_parent;
                    r_mem[w_right] <= bus.ce_new_right;
                    if (!bus.ce_stable) r_dirty <= 1'b1;
                    if (w_last) r_sweep <= r_sweep + SW'(1);
                    else        r_idx   <= r_idx + AW'(1);
                end
                S_CHECK: begin
                    if (r_dirty && w_limit) begin
                        r_timeout <= 1'b1;
                    end else if (r_dirty) begin
                        r_idx   <= '0;
                        r_dirty <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data       = (bus.rd_addr < AW'(N)) ? r_mem[bus.rd_addr] : '0;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = w_done;
    assign bus.timeout       = r_timeout;
    assign bus.sweep_count   = r_sweep;
    assign bus.ce_en         = w_eval;
    assign bus.ce_sorting    = w_eval;
    assign bus.ce_point_prop = 1'b0;
    assign bus.ce_left_en    = w_eval;
    assign bus.ce_right_en   = w_eval;
    assign bus.ce_left       = r_op_left_p0;
    assign bus.ce_parent     = r_op_parent_p0;
    assign bus.ce_right      = r_op_right_p0;
    assign bus.ce_axis       = r_op_axis_p0;
endmodule

// File: tb/tb_kd_sort_sequencer.sv
// Directed bench for kd_sort_sequencer: a behavioural compare-exchange element
// sorts each triplet along the presented axis; expectations are hand-derived.
module tb_kd_sort_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [23:0] sorted_img [7];
    logic [23:0] swap_img   [7];

    kd_sort_sequencer_if                    a_if ();
    kd_sort_sequencer_if #(.MAX_SWEEPS(1))  b_if ();

    kd_sort_sequencer u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
    kd_sort_sequencer #(.MAX_SWEEPS(1)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] cen(input int x, input int y, input int z);
        return {8'(z), 8'(y), 8'(x)};
    endfunction

    function automatic logic [7:0] key(input logic [23:0] c, input logic [1:0] ax);
        case (ax)
            2'd0:    return c[7:0];
            2'd1:    return c[15:8];
            default: return c[23:16];
        endcase
    endfunction

    // Returns {stable, new_left, new_parent, new_right}.
    function automatic logic [72:0] ce_model(input logic [23:0] l, input logic [23:0] p,
                                             input logic [23:0] r, input logic [1:0] ax);
        logic [23:0] a, b, c, t;
        logic        st;
        a = l; b = p; c = r;
        st = (key(l, ax) <= key(p, ax)) && (key(p, ax) <= key(r, ax));
        if (key(a, ax) > key(b, ax)) begin t = a; a = b; b = t; end
        if (key(b, ax) > key(c, ax)) begin t = b; b = c; c = t; end
        if (key(a, ax) > key(b, ax)) begin t = a; a = b; b = t; end
        return {st, a, b, c};
    endfunction

    assign {a_if.ce_stable, a_if.ce_new_left, a_if.ce_new_parent, a_if.ce_new_right} =
        ce_model(a_if.ce_left, a_if.ce_parent, a_if.ce_right, a_if.ce_axis);
    assign {b_if.ce_stable, b_if.ce_new_left, b_if.ce_new_parent, b_if.ce_new_right} =
        ce_model(b_if.ce_left, b_if.ce_parent, b_if.ce_right, b_if.ce_axis);

    task automatic write_a(input int addr, input logic [23:0] d);
        @(negedge clk);
        a_if.wr_en = 1'b1; a_if.wr_addr = 3'(addr); a_if.wr_data = d;
        @(negedge clk);
        a_if.wr_en = 1'b0;
    endtask

    task automatic write_b(input int addr, input logic [23:0] d);
        @(negedge clk);
        b_if.wr_en = 1'b1; b_if.wr_addr = 3'(addr); b_if.wr_data = d;
        @(negedge clk);
        b_if.wr_en = 1'b0;
    endtask

    // Leaves the caller at the negedge of cycle t+1 (start sampled at edge t).
    task automatic start_a();
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk);
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_if.busy); end
        total++; if (a_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", a_if.done); end
        total++; if (a_if.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", a_if.timeout); end
        total++; if (a_if.sweep_count !== 5'd0) begin bad++; $display("FAIL reset_sweep: got %0d want 0", a_if.sweep_count); end
        total++; if ({a_if.ce_en, a_if.ce_sorting, a_if.ce_left_en, a_if.ce_right_en, a_if.ce_point_prop} !== 5'b0)
            begin bad++; $display("FAIL reset_ce_flags: got %b want 00000",
                {a_if.ce_en, a_if.ce_sorting, a_if.ce_left_en, a_if.ce_right_en, a_if.ce_point_prop}); end
        total++; if ({a_if.ce_left, a_if.ce_parent, a_if.ce_right, a_if.ce_axis} !== 74'd0)
            begin bad++; $display("FAIL reset_ce_ops: got %h want 0", {a_if.ce_left, a_if.ce_parent, a_if.ce_right, a_if.ce_axis}); end
        for (int e = 0; e < 7; e++) begin
            a_if.rd_addr = 3'(e);
            #1;
            total++; if (a_if.rd_data !== 24'd0) begin bad++; $display("FAIL reset_mem%0d: got %h want 000000", e, a_if.rd_data); end
        end
    endtask

    task automatic test_sorted();
        int done_at;
        int done_cnt;
        int k;
        for (int e = 0; e < 7; e++) write_a(e, sorted_img[e]);
        start_a();
        total++; if (a_if.busy !== 1'b1) begin bad++; $display("FAIL sorted_busy: got %b want 1", a_if.busy); end
        done_at = -1; done_cnt = 0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2 || c == 4 || c == 6) begin
                k = (c - 2) / 2;
                total++; if ({a_if.ce_en, a_if.ce_sorting, a_if.ce_left_en, a_if.ce_right_en, a_if.ce_point_prop} !== 5'b11110)
                    begin bad++; $display("FAIL eval_flags_i%0d: got %b want 11110", k,
                        {a_if.ce_en, a_if.ce_sorting, a_if.ce_left_en, a_if.ce_right_en, a_if.ce_point_prop}); end
                total++; if (a_if.ce_axis !== ((k == 0) ? 2'd0 : 2'd1))
                    begin bad++; $display("FAIL axis_i%0d: got %0d want %0d", k, a_if.ce_axis, (k == 0) ? 0 : 1); end
                total++; if ({a_if.ce_left, a_if.ce_parent, a_if.ce_right} !== {sorted_img[2*k+1], sorted_img[k], sorted_img[2*k+2]})
                    begin bad++; $display("FAIL operands_i%0d: got %h want %h", k, {a_if.ce_left, a_if.ce_parent, a_if.ce_right},
                        {sorted_img[2*k+1], sorted_img[k], sorted_img[2*k+2]}); end
            end
            if (c == 3) begin
                total++; if (a_if.ce_en !== 1'b0) begin bad++; $display("FAIL issue_ce_en: got %b want 0", a_if.ce_en); end
            end
            if (c == 7) begin
                total++; if (a_if.busy !== 1'b1 || a_if.done !== 1'b0)
                    begin bad++; $display("FAIL check_cycle: got busy=%b done=%b want busy=1 done=0", a_if.busy, a_if.done); end
            end
            if (a_if.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        total++; if (done_at != 8) begin bad++; $display("FAIL sorted_done_cycle: got %0d want 8", done_at); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL sorted_done_pulses: got %0d want 1", done_cnt); end
        total++; if (a_if.sweep_count !== 5'd1) begin bad++; $display("FAIL sorted_sweeps: got %0d want 1", a_if.sweep_count); end
        total++; if (a_if.timeout !== 1'b0) begin bad++; $display("FAIL sorted_timeout: got %b want 0", a_if.timeout); end
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL sorted_idle: got %b want 0", a_if.busy); end
        for (int e = 0; e < 7; e++) begin
            a_if.rd_addr = 3'(e);
            #1;
            total++; if (a_if.rd_data !== sorted_img[e]) begin bad++; $display("FAIL sorted_mem%0d: got %h want %h", e, a_if.rd_data, sorted_img[e]); end
        end
    endtask

    task automatic test_root_swap();
        int done_at;
        for (int e = 0; e < 7; e++) write_a(e, swap_img[e]);
        a_if.rd_addr = 3'd0;
        start_a();
        done_at = -1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                total++; if ({a_if.ce_left[7:0], a_if.ce_parent[7:0], a_if.ce_right[7:0]} !== {8'd50, 8'd200, 8'd100})
                    begin bad++; $display("FAIL swap_first_eval_x: got %h want 32c864",
                        {a_if.ce_left[7:0], a_if.ce_parent[7:0], a_if.ce_right[7:0]}); end
            end
            if (c == 3) begin
                total++; if (a_if.rd_data[7:0] !== 8'd100) begin bad++; $display("FAIL swap_writeback_x: got %0d want 100", a_if.rd_data[7:0]); end
            end
            if (a_if.done === 1'b1 && done_at < 0) done_at = c;
        end
        total++; if (done_at != 15) begin bad++; $display("FAIL swap_done_cycle: got %0d want 15", done_at); end
        total++; if (a_if.sweep_count !== 5'd2) begin bad++; $display("FAIL swap_sweeps: got %0d want 2", a_if.sweep_count); end
        total++; if (a_if.timeout !== 1'b0) begin bad++; $display("FAIL swap_timeout: got %b want 0", a_if.timeout); end
        a_if.rd_addr = 3'd0; #1;
        total++; if (a_if.rd_data !== cen(100, 100, 2)) begin bad++; $display("FAIL swap_node0: got %h want %h", a_if.rd_data, cen(100, 100, 2)); end
        a_if.rd_addr = 3'd2; #1;
        total++; if (a_if.rd_data !== cen(200, 100, 0)) begin bad++; $display("FAIL swap_node2: got %h want %h", a_if.rd_data, cen(200, 100, 0)); end
    endtask

    task automatic test_ignored();
        int done_at;
        for (int e = 0; e < 7; e++) write_a(e, sorted_img[e]);
        start_a();
        done_at = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (a_if.done === 1'b1 && done_at < 0) done_at = c;
            if (c == 10) begin
                total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL done_start_ignored: got busy=%b want 0", a_if.busy); end
            end
            if (c == 3) begin
                a_if.wr_en = 1'b1; a_if.wr_addr = 3'd3; a_if.wr_data = 24'hFFFFFF; a_if.start = 1'b1;
            end else if (c == 8) begin
                a_if.start = 1'b1;
            end else begin
                a_if.wr_en = 1'b0; a_if.start = 1'b0;
            end
        end
        total++; if (done_at != 8) begin bad++; $display("FAIL busy_start_done_cycle: got %0d want 8", done_at); end
        total++; if (a_if.sweep_count !== 5'd1) begin bad++; $display("FAIL busy_start_sweeps: got %0d want 1", a_if.sweep_count); end
        a_if.rd_addr = 3'd3; #1;
        total++; if (a_if.rd_data !== sorted_img[3]) begin bad++; $display("FAIL busy_write_node3: got %h want %h", a_if.rd_data, sorted_img[3]); end
    endtask

    task automatic test_timeout();
        int done_at;
        for (int e = 0; e < 7; e++) write_b(e, swap_img[e]);
        start_b();
        done_at = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (b_if.done === 1'b1 && done_at < 0) begin
                done_at = c;
                total++; if (b_if.timeout !== 1'b1) begin bad++; $display("FAIL timeout_at_done: got %b want 1", b_if.timeout); end
            end
        end
        total++; if (done_at != 8) begin bad++; $display("FAIL timeout_done_cycle: got %0d want 8", done_at); end
        total++; if (b_if.sweep_count !== 5'd1) begin bad++; $display("FAIL timeout_sweeps: got %0d want 1", b_if.sweep_count); end
        b_if.rd_addr = 3'd0; #1;
        total++; if (b_if.rd_data[7:0] !== 8'd100) begin bad++; $display("FAIL timeout_node0_x: got %0d want 100", b_if.rd_data[7:0]); end
        for (int e = 0; e < 7; e++) write_b(e, sorted_img[e]);
        total++; if (b_if.timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", b_if.timeout); end
        start_b();
        total++; if (b_if.timeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared: got %b want 0", b_if.timeout); end
        done_at = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (b_if.done === 1'b1 && done_at < 0) done_at = c;
        end
        total++; if (done_at != 8) begin bad++; $display("FAIL timeout_rerun_done: got %0d want 8", done_at); end
        total++; if (b_if.timeout !== 1'b0) begin bad++; $display("FAIL timeout_rerun_flag: got %b want 0", b_if.timeout); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        for (int e = 0; e < 7; e++) write_a(e, swap_img[e]);
        start_a();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", a_if.busy); end
        total++; if (a_if.ce_en !== 1'b0) begin bad++; $display("FAIL midrst_ce_en: got %b want 0", a_if.ce_en); end
        total++; if (a_if.sweep_count !== 5'd0) begin bad++; $display("FAIL midrst_sweeps: got %0d want 0", a_if.sweep_count); end
        done_seen = 0;
        for (int e = 0; e < 7; e++) begin
            a_if.rd_addr = 3'(e);
            #1;
            total++; if (a_if.rd_data !== 24'd0) begin bad++; $display("FAIL midrst_mem%0d: got %h want 000000", e, a_if.rd_data); end
            if (a_if.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        for (int c = 0; c < 10; c++) begin
            if (a_if.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL midrst_done: got %0d pulses want 0", done_seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        a_if.start = 1'b0; a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.rd_addr = '0;
        b_if.start = 1'b0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.rd_addr = '0;
        sorted_img[0] = cen(100, 100, 0); sorted_img[1] = cen(50, 100, 1); sorted_img[2] = cen(150, 100, 2);
        sorted_img[3] = cen(10, 50, 3);   sorted_img[4] = cen(20, 150, 4); sorted_img[5] = cen(30, 50, 5);
        sorted_img[6] = cen(40, 150, 6);
        for (int e = 0; e < 7; e++) swap_img[e] = sorted_img[e];
        swap_img[0] = cen(200, 100, 0);
        swap_img[2] = cen(100, 100, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_sorted();
        test_root_swap();
        test_ignored();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
